// File: rtl/rca_accumulator_pkg.sv
// Shared types and constants for the RCA-based accumulator.
package rca_accumulator_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Two's-complement overflow: equal-signed operands producing a differently signed sum.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/SixteenBitRCA_str.sv
// 16-bit structural ripple-carry adder built from gate-level full adders.
module SixteenBitRCA_str (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] w_c;

  assign w_c[0] = c_in;
  assign c_out  = w_c[16];

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  endgenerate

endmodule

// File: rtl/ThirtyTwoBitRCA_str.sv
// 32-bit structural ripple-carry adder: two 16-bit RCAs with the carry chained between them.
module ThirtyTwoBitRCA_str (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic w_c_mid;

  SixteenBitRCA_str u_lo (
    .a     (a[15:0]),
    .b     (b[15:0]),
    .c_in  (c_in),
    .sum   (sum[15:0]),
    .c_out (w_c_mid)
  );

  SixteenBitRCA_str u_hi (
    .a     (a[31:16]),
    .b     (b[31:16]),
    .c_in  (w_c_mid),
    .sum   (sum[31:16]),
    .c_out (c_out)
  );

endmodule

// File: rtl/rca_accumulator.sv
// Streaming add/subtract accumulator in front of the 32-bit structural RCA,
// with valid/ready operand intake and a sticky-flag result handshake.
module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_ops,
  input  logic              sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_flag,
  output logic              ovf_flag,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_remaining;
  logic                r_carry;
  logic                r_ovf;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_sum;
  logic                w_c_out;
  logic                w_hs;
  logic                w_last;
  logic                w_carry_ev;
  logic                w_ovf_ev;

  // Subtraction is acc + ~data + 1, with the +1 entering as the RCA carry-in.
  assign w_b = sub ? ~in_data : in_data;

  ThirtyTwoBitRCA_str u_rca (
    .a     (r_acc),
    .b     (w_b),
    .c_in  (sub),
    .sum   (w_sum),
    .c_out (w_c_out)
  );

  assign w_hs       = in_valid & in_ready;
  assign w_last     = (r_remaining == CNT_ONE);
  assign w_carry_ev = sub ? ~w_c_out : w_c_out;
  assign w_ovf_ev   = ovf_detect(r_acc[DATA_W-1], w_b[DATA_W-1], w_sum[DATA_W-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (num_ops != CNT_ZERO) ? ST_ACCUM : ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_hs && w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
      ST_ACCUM: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Accumulator, sticky flags and remaining-operand counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= {DATA_W{1'b0}};
      r_remaining <= CNT_ZERO;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc       <= {DATA_W{1'b0}};
            r_remaining <= num_ops;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (w_hs) begin
            r_acc       <= w_sum;
            r_remaining <= r_remaining - CNT_ONE;
            r_carry     <= r_carry | w_carry_ev;
            r_ovf       <= r_ovf | w_ovf_ev;
          end
        end
        ST_DONE: begin
          r_acc <= r_acc;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  // Result and flags remain readable after DONE until the next start.
  assign result     = r_acc;
  assign carry_flag = r_carry;
  assign ovf_flag   = r_ovf;

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator: an independent 33-bit reference model feeds
// a scoreboard queue that is drained whenever the DUT presents a result.
module tb_rca_accumulator;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_ops;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_flag;
  logic        ovf_flag;
  logic        busy;

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        sb_q[$];
  logic [31:0] m_acc;
  logic        m_c;
  logic        m_o;

  rca_accumulator #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_ops    (num_ops),
    .sub        (sub),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".in_ready"},  {31'd0, in_ready},   32'd0);
    chk({tag, ".out_valid"}, {31'd0, out_valid},  32'd0);
    chk({tag, ".busy"},      {31'd0, busy},       32'd0);
    chk({tag, ".result"},    result,              32'd0);
    chk({tag, ".carry"},     {31'd0, carry_flag}, 32'd0);
    chk({tag, ".ovf"},       {31'd0, ovf_flag},   32'd0);
  endtask

  task automatic start_batch(input logic [7:0] n);
    start   = 1'b1;
    num_ops = n;
    tick();
    start   = 1'b0;
    num_ops = 8'd0;
    m_acc   = 32'd0;
    m_c     = 1'b0;
    m_o     = 1'b0;
  endtask

  // One ACCUM cycle; the reference model only advances on a handshaked beat.
  task automatic beat(input logic [31:0] d, input logic s, input logic v);
    logic [32:0] t;
    in_data  = d;
    sub      = s;
    in_valid = v;
    chk("accum.in_ready", {31'd0, in_ready}, 32'd1);
    chk("accum.busy",     {31'd0, busy},     32'd1);
    if (v) begin
      if (!s) begin
        t   = {1'b0, m_acc} + {1'b0, d};
        m_c = m_c | t[32];
        m_o = m_o | ((m_acc[31] == d[31]) && (t[31] != m_acc[31]));
      end else begin
        t   = {1'b0, m_acc} - {1'b0, d};
        m_c = m_c | t[32];
        m_o = m_o | ((m_acc[31] != d[31]) && (t[31] != m_acc[31]));
      end
      m_acc = t[31:0];
    end
    tick();
    in_valid = 1'b0;
    sub      = 1'b0;
    in_data  = 32'd0;
  endtask

  task automatic push_exp();
    sb_q.push_back('{res: m_acc, c: m_c, o: m_o});
  endtask

  // Result must appear immediately, hold while out_ready is low, drop after acceptance.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".out_valid_hold"}, {31'd0, out_valid}, 32'd1);
    end
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
      e = '0;
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".result"}, result,              e.res);
      chk({tag, ".carry"},  {31'd0, carry_flag}, {31'd0, e.c});
      chk({tag, ".ovf"},    {31'd0, ovf_flag},   {31'd0, e.o});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".busy_idle"},      {31'd0, busy},      32'd0);
    chk({tag, ".in_ready_idle"},  {31'd0, in_ready},  32'd0);
    chk({tag, ".result_idle"},    result,             e.res);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = 8'd0;
    sub       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    m_acc     = 32'd0;
    m_c       = 1'b0;
    m_o       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    // 5 + 10 + 20 with in_valid held high
    start_batch(8'd3);
    beat(32'd5,  1'b0, 1'b1);
    beat(32'd10, 1'b0, 1'b1);
    beat(32'd20, 1'b0, 1'b1);
    push_exp();
    collect("sum3", 0);

    // Unsigned carry out
    start_batch(8'd2);
    beat(32'hFFFF_FFFF, 1'b0, 1'b1);
    beat(32'h0000_0002, 1'b0, 1'b1);
    push_exp();
    collect("carry", 0);

    // Signed overflow without carry
    start_batch(8'd2);
    beat(32'h7FFF_FFFF, 1'b0, 1'b1);
    beat(32'h0000_0001, 1'b0, 1'b1);
    push_exp();
    collect("ovf", 1);

    // 3 - 5 borrows
    start_batch(8'd2);
    beat(32'd3, 1'b0, 1'b1);
    beat(32'd5, 1'b1, 1'b1);
    push_exp();
    collect("borrow", 0);

    // Gapped in_valid: idle beats carry junk data that must be ignored
    start_batch(8'd4);
    beat(32'd1,         1'b0, 1'b1);
    beat(32'hDEAD_BEEF, 1'b0, 1'b0);
    beat(32'd2,         1'b0, 1'b1);
    beat(32'hDEAD_BEEF, 1'b1, 1'b0);
    beat(32'd3,         1'b0, 1'b1);
    beat(32'd4,         1'b0, 1'b1);
    push_exp();
    collect("gapped", 3);

    // Empty batch goes straight to DONE with a cleared accumulator
    start_batch(8'd0);
    push_exp();
    collect("empty", 1);

    // Mixed random add/sub batch
    start_batch(8'd6);
    for (int i = 0; i < 6; i++) begin
      beat($urandom(), 1'($urandom_range(1, 0)), 1'b1);
    end
    push_exp();
    collect("random", 2);

    // Reset mid-batch, after the carry flag has been set
    start_batch(8'd4);
    beat(32'hFFFF_FFFF, 1'b0, 1'b1);
    beat(32'h0000_0002, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("midreset");

    start_batch(8'd1);
    beat(32'd7, 1'b0, 1'b1);
    push_exp();
    collect("after_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
